// File: rtl/logic_seq_pkg.sv
// Shared definitions for the operand sequencer.
//
// Holds the FSM state encoding (also the value shown on the status LEDs),
// the op-select codes understood by the downstream 4-bit logic unit, and a
// small helper that classifies an encoded state value as legal or not.
//
// The button conditioner's optional debounce stage is controlled by the
// DEBOUNCE_EN macro (see btn_conditioner.sv); nothing in this package
// depends on it.

package logic_seq_pkg;

  localparam int unsigned STATE_W = 3;

  // State encoding as seen on state_out.
  localparam logic [STATE_W-1:0] LD_X  = 3'd0;
  localparam logic [STATE_W-1:0] LD_Y  = 3'd1;
  localparam logic [STATE_W-1:0] LD_OP = 3'd2;
  localparam logic [STATE_W-1:0] EVAL  = 3'd3;
  localparam logic [STATE_W-1:0] HOLD  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    StLdX  = LD_X,
    StLdY  = LD_Y,
    StLdOp = LD_OP,
    StEval = EVAL,
    StHold = HOLD
  } state_e;

  // Op-select codes driven on s_out.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  // Encodings above HOLD are unused; the FSM recovers from them to LD_X.
  function automatic logic is_legal_state(input logic [STATE_W-1:0] st);
    return st <= HOLD;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: turns a raw, asynchronous button level into a
// single-cycle press pulse in the clk domain.
//
//   raw -> 2-flop synchroniser -> [debounce] -> edge detect -> press
//
// Configuration:
//   DEBOUNCE_EN defined   - the conditioned level only follows the
//                           synchronised level after it has differed for
//                           DB_CYCLES consecutive cycles (adds DB_CYCLES
//                           cycles of press latency).
//   DEBOUNCE_EN undefined - the conditioned level is the synchroniser output.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-high reset, clears every stage
//   raw   in  raw pushbutton level (asynchronous to clk)
//   press out one-cycle pulse on each rising edge of the conditioned level

module btn_conditioner #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("DB_CYCLES must be at least 1");
  end

  logic sync_meta;
  logic btn_sync;
  logic btn_c;
  logic btn_c_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      sync_meta <= raw;
      btn_sync  <= sync_meta;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

  logic            btn_db;
  logic [CntW-1:0] db_cnt;

  // The counter tracks how long the synchronised level has disagreed with the
  // accepted level; any agreement (a bounce back) restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_sync != btn_db) begin
      if (db_cnt == CntW'(DB_CYCLES - 1)) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign btn_c = btn_db;
`else
  assign btn_c = btn_sync;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_c_prev <= 1'b0;
    end else begin
      btn_c_prev <= btn_c;
    end
  end

  assign press = btn_c & ~btn_c_prev;

endmodule

// File: rtl/operand_sequencer.sv
// Front-end for the 4-bit logic unit.
//
// Successive button presses load operand x, operand y and the op select from
// the board switches. After the op select is loaded, one settle cycle lets the
// combinational logic unit produce its result, which is then captured and held
// with a valid flag until the consumer acknowledges it.
//
// Configuration: DEBOUNCE_EN (passed through to btn_conditioner) enables the
// DB_CYCLES-cycle debounce stage on load_btn.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   sw_in        in   W-bit operand switches, sampled on a press in LD_X/LD_Y
//   sel_in       in   op-select switches, sampled on a press in LD_OP
//   load_btn     in   raw pushbutton, asynchronous
//   ack_in       in   consumer acknowledge (level), honoured only in HOLD
//   x_out        out  registered operand x to the logic unit
//   y_out        out  registered operand y to the logic unit
//   s_out        out  registered op select to the logic unit
//   result_in    in   2W-bit combinational result from the logic unit
//   result_q     out  captured result
//   result_valid out  high while result_q awaits acknowledge
//   state_out    out  current FSM state for status LEDs

module operand_sequencer
  import logic_seq_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       sw_in,
  input  logic [1:0]         sel_in,
  input  logic               load_btn,
  input  logic               ack_in,
  output logic [W-1:0]       x_out,
  output logic [W-1:0]       y_out,
  output logic [1:0]         s_out,
  input  logic [2*W-1:0]     result_in,
  output logic [2*W-1:0]     result_q,
  output logic               result_valid,
  output logic [STATE_W-1:0] state_out
);

  logic   press;
  state_e state;

  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_conditioner (
    .clk   (clk),
    .rst   (rst),
    .raw   (load_btn),
    .press (press)
  );

  // Single registered FSM; operand and result registers only change on the
  // transition that loads them, so they hold across every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StLdX;
      x_out        <= '0;
      y_out        <= '0;
      s_out        <= '0;
      result_q     <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        StLdX: begin
          if (press) begin
            x_out <= sw_in;
            state <= StLdY;
          end
        end
        StLdY: begin
          if (press) begin
            y_out <= sw_in;
            state <= StLdOp;
          end
        end
        StLdOp: begin
          if (press) begin
            s_out <= sel_in;
            state <= StEval;
          end
        end
        // s_out changed on the previous edge; result_in has settled by now.
        StEval: begin
          result_q     <= result_in;
          result_valid <= 1'b1;
          state        <= StHold;
        end
        // Presses here are dropped, including one coinciding with ack.
        StHold: begin
          if (ack_in) begin
            result_valid <= 1'b0;
            state        <= StLdX;
          end
        end
        default: begin
          state <= StLdX;
        end
      endcase
    end
  end

  assign state_out = state;

  // Keeps the legality helper tied to the live state encoding.
  logic state_legal;
  assign state_legal = is_legal_state(state);

  logic unused_state_legal;
  assign unused_state_legal = state_legal;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;
  import logic_seq_pkg::*;

`ifdef DEBOUNCE_EN
  localparam int PressLat = 3 + 16;
`else
  localparam int PressLat = 3;
`endif
  localparam int PressHold = PressLat + 2;

  logic       clk;
  logic       rst;
  logic [3:0] sw_in;
  logic [1:0] sel_in;
  logic       load_btn;
  logic       ack_in;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic [1:0] s_out;
  logic [7:0] result_in;
  logic [7:0] result_q;
  logic       result_valid;
  logic [2:0] state_out;

  operand_sequencer #(
    .W         (4),
    .DB_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_in        (sw_in),
    .sel_in       (sel_in),
    .load_btn     (load_btn),
    .ack_in       (ack_in),
    .x_out        (x_out),
    .y_out        (y_out),
    .s_out        (s_out),
    .result_in    (result_in),
    .result_q     (result_q),
    .result_valid (result_valid),
    .state_out    (state_out)
  );

  // Stand-in for the 4-bit logic unit.
  always_comb begin
    result_in = 8'h00;
    case (s_out)
      OP_AND:  result_in = {4'h0, x_out & y_out};
      OP_OR:   result_in = {4'h0, x_out | y_out};
      OP_XOR:  result_in = {4'h0, x_out ^ y_out};
      default: result_in = ~{y_out, x_out};
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] sel;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] exp_q[$];
  logic [7:0] exp_val;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press_btn();
    load_btn = 1'b1;
    repeat (PressHold) tick();
    load_btn = 1'b0;
    repeat (PressHold) tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    load_btn = 1'b0;
    ack_in   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_all(input logic [3:0] x, input logic [3:0] y, input logic [1:0] sel);
    sw_in = x;
    press_btn();
    sw_in = y;
    press_btn();
    sel_in = sel;
    press_btn();
  endtask

  // Bounded wait for result_valid, then compare against the scoreboard head.
  task automatic wait_and_score(input string name);
    int n;
    n = 0;
    while (!result_valid && n < 100) begin
      tick();
      n++;
    end
    check({name, "_valid"}, {31'd0, result_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
      exp_val = 8'hxx;
    end else begin
      exp_val = exp_q.pop_front();
      check({name, "_result"}, {24'd0, result_q}, {24'd0, exp_val});
    end
    check({name, "_state_hold"}, {29'd0, state_out}, {29'd0, HOLD});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sw_in    = '0;
    sel_in   = '0;
    load_btn = 1'b0;
    ack_in   = 1'b0;

    vecs[0] = '{x: 4'hA, y: 4'h6, sel: 2'b00, exp: 8'h02};
    vecs[1] = '{x: 4'hA, y: 4'h6, sel: 2'b11, exp: 8'h95};
    vecs[2] = '{x: 4'hA, y: 4'h6, sel: 2'b01, exp: 8'h0E};
    vecs[3] = '{x: 4'hA, y: 4'h6, sel: 2'b10, exp: 8'h0C};
    vecs[4] = '{x: 4'hF, y: 4'h0, sel: 2'b01, exp: 8'h0F};
    vecs[5] = '{x: 4'h3, y: 4'hC, sel: 2'b00, exp: 8'h00};
    vecs[6] = '{x: 4'h5, y: 4'h5, sel: 2'b10, exp: 8'h00};
    vecs[7] = '{x: 4'h0, y: 4'h0, sel: 2'b11, exp: 8'hFF};
    vecs[8] = '{x: 4'h9, y: 4'h3, sel: 2'b11, exp: 8'hC6};
    vecs[9] = '{x: 4'hC, y: 4'h3, sel: 2'b10, exp: 8'h0F};

    do_reset();
    check("rst_state", {29'd0, state_out}, {29'd0, LD_X});
    check("rst_x", {28'd0, x_out}, 32'd0);
    check("rst_y", {28'd0, y_out}, 32'd0);
    check("rst_s", {30'd0, s_out}, 32'd0);
    check("rst_result", {24'd0, result_q}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);

    // ack outside HOLD is ignored
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    check("ack_ldx_state", {29'd0, state_out}, {29'd0, LD_X});

    // Press latency: state must not move one edge early
    sw_in    = 4'h1;
    load_btn = 1'b1;
    repeat (PressLat - 1) tick();
    check("lat_early_state", {29'd0, state_out}, {29'd0, LD_X});
    tick();
    check("lat_state", {29'd0, state_out}, {29'd0, LD_Y});
    check("lat_x", {28'd0, x_out}, 32'd1);
    load_btn = 1'b0;
    repeat (PressHold) tick();
    do_reset();

    // Table-driven full transactions
    for (int i = 0; i < 10; i++) begin
      load_all(vecs[i].x, vecs[i].y, vecs[i].sel);
      exp_q.push_back(vecs[i].exp);
      wait_and_score($sformatf("vec%0d", i));
      // A press while holding is dropped
      sw_in = 4'h7;
      press_btn();
      check($sformatf("vec%0d_hold_press_state", i), {29'd0, state_out}, {29'd0, HOLD});
      check($sformatf("vec%0d_hold_press_x", i), {28'd0, x_out}, {28'd0, vecs[i].x});
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      check($sformatf("vec%0d_ack_valid", i), {31'd0, result_valid}, 32'd0);
      check($sformatf("vec%0d_ack_state", i), {29'd0, state_out}, {29'd0, LD_X});
      check($sformatf("vec%0d_ack_keep", i), {24'd0, result_q}, {24'd0, vecs[i].exp});
    end

    // Press and ack in the same HOLD cycle: ack wins, press dropped
    load_all(4'h5, 4'h3, 2'b01);
    exp_q.push_back(8'h07);
    wait_and_score("pa");
    sw_in    = 4'h9;
    load_btn = 1'b1;
    repeat (PressLat - 1) tick();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    check("pa_state", {29'd0, state_out}, {29'd0, LD_X});
    check("pa_x", {28'd0, x_out}, 32'h5);
    repeat (PressHold) tick();
    load_btn = 1'b0;
    repeat (PressHold) tick();
    check("pa_no_late_state", {29'd0, state_out}, {29'd0, LD_X});
    check("pa_no_late_x", {28'd0, x_out}, 32'h5);
    sw_in = 4'hE;
    press_btn();
    check("pa_fresh_state", {29'd0, state_out}, {29'd0, LD_Y});
    check("pa_fresh_x", {28'd0, x_out}, 32'hE);

    // Button held 100 cycles: exactly one load
    do_reset();
    sw_in    = 4'h7;
    load_btn = 1'b1;
    repeat (100) tick();
    check("held_state", {29'd0, state_out}, {29'd0, LD_Y});
    check("held_x", {28'd0, x_out}, 32'h7);
    load_btn = 1'b0;
    repeat (PressHold) tick();
    check("held_rel_state", {29'd0, state_out}, {29'd0, LD_Y});
    check("held_y", {28'd0, y_out}, 32'h0);

    // Reset mid-load in LD_OP
    do_reset();
    sw_in = 4'h3;
    press_btn();
    sw_in = 4'hC;
    press_btn();
    check("mid_pre_state", {29'd0, state_out}, {29'd0, LD_OP});
    check("mid_pre_y", {28'd0, y_out}, 32'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_state", {29'd0, state_out}, {29'd0, LD_X});
    check("mid_x", {28'd0, x_out}, 32'd0);
    check("mid_y", {28'd0, y_out}, 32'd0);
    check("mid_s", {30'd0, s_out}, 32'd0);
    check("mid_result", {24'd0, result_q}, 32'd0);
    check("mid_valid", {31'd0, result_valid}, 32'd0);

`ifdef DEBOUNCE_EN
    // A 15-cycle pulse is one cycle short of the debounce window
    sw_in    = 4'hB;
    load_btn = 1'b1;
    repeat (15) tick();
    load_btn = 1'b0;
    repeat (40) tick();
    check("db_glitch_state", {29'd0, state_out}, {29'd0, LD_X});
    check("db_glitch_x", {28'd0, x_out}, 32'd0);
    // A stable level is accepted as exactly one press
    press_btn();
    check("db_stable_state", {29'd0, state_out}, {29'd0, LD_Y});
    check("db_stable_x", {28'd0, x_out}, 32'hB);
`endif

    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait is never satisfied.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
